// File: rtl/des_region_scheduler.sv
// Hands a contiguous range of DES key-search regions to a pool of wrappers
// and funnels their {region, counter} results onto one valid/ready stream.
module des_region_scheduler #(
    parameter int NUM_WORKERS = 4,
    parameter int WID_W       = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic                      abort,
    input  logic [31:0]               region_base,
    input  logic [31:0]               region_count,
    output logic                      busy,
    output logic                      job_done,
    output logic [32*NUM_WORKERS-1:0] w_cmd,
    output logic [NUM_WORKERS-1:0]    w_cmd_valid,
    output logic [32*NUM_WORKERS-1:0] w_region,
    input  logic [NUM_WORKERS-1:0]    w_cmd_read,
    input  logic [NUM_WORKERS-1:0]    w_done,
    input  logic [64*NUM_WORKERS-1:0] w_counter,
    output logic                      res_valid,
    input  logic                      res_ready,
    output logic [31:0]               res_region,
    output logic [63:0]               res_counter,
    output logic [WID_W-1:0]          res_worker
);

    localparam logic [2:0] W_IDLE   = 3'd0;
    localparam logic [2:0] W_LOAD   = 3'd1;
    localparam logic [2:0] W_GO     = 3'd2;
    localparam logic [2:0] W_RUN    = 3'd3;
    localparam logic [2:0] W_RESULT = 3'd4;
    localparam logic [2:0] W_RST    = 3'd5;

    localparam logic [31:0] CMD_READ    = 32'd0;
    localparam logic [31:0] CMD_START   = 32'd1;
    localparam logic [31:0] CMD_RESTART = 32'd3;

    logic [2:0]             st  [NUM_WORKERS];
    logic [31:0]            rgn [NUM_WORKERS];
    logic [63:0]            cnt [NUM_WORKERS];
    logic [NUM_WORKERS-1:0] hs;
    logic [31:0]            next_region;
    logic [31:0]            remaining;
    logic                   aborting;
    logic [WID_W-1:0]       rr_ptr;
    logic                   all_idle;
    logic                   gnt_ok;
    logic                   alloc;
    logic                   job_end;
    logic                   sel_ok;
    logic                   accept;
    logic [WID_W-1:0]       gnt_idx;
    logic [WID_W-1:0]       sel_idx;

    assign accept = res_valid && res_ready;

    // Lowest idle worker gets the next region; detect end of job
    always_comb begin
        all_idle = 1'b1;
        gnt_ok   = 1'b0;
        gnt_idx  = '0;
        for (int i = NUM_WORKERS - 1; i >= 0; i--) begin
            if (st[i] == W_IDLE) begin
                gnt_ok  = 1'b1;
                gnt_idx = WID_W'(i);
            end else begin
                all_idle = 1'b0;
            end
        end
        alloc   = busy && (remaining != 32'd0) && !aborting && !abort && gnt_ok;
        job_end = busy && all_idle && !res_valid &&
                  ((remaining == 32'd0) || aborting);
    end

    // Round-robin pick: reporting worker closest at or after rr_ptr
    always_comb begin
        int d;
        int best;
        d       = 0;
        best    = NUM_WORKERS;
        sel_ok  = 1'b0;
        sel_idx = '0;
        for (int i = 0; i < NUM_WORKERS; i++) begin
            if (st[i] == W_RESULT) begin
                d = i - int'(rr_ptr);
                if (d < 0) d = d + NUM_WORKERS;
                if (d < best) begin
                    best    = d;
                    sel_ok  = 1'b1;
                    sel_idx = WID_W'(i);
                end
            end
        end
    end

    // Per-worker sequencing: load, start, run, report, restart
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hs <= '0;
            for (int i = 0; i < NUM_WORKERS; i++) begin
                st[i]  <= W_IDLE;
                rgn[i] <= '0;
                cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_WORKERS; i++) begin
                unique case (st[i])
                    W_IDLE: begin
                        if (alloc && gnt_idx == WID_W'(i)) begin
                            st[i]  <= W_LOAD;
                            rgn[i] <= next_region;
                        end
                    end
                    W_LOAD, W_GO, W_RST: begin
                        if (!hs[i]) begin
                            if (w_cmd_read[i]) hs[i] <= 1'b1;
                        end else if (!w_cmd_read[i]) begin
                            hs[i] <= 1'b0;
                            if (st[i] == W_RST)       st[i] <= W_IDLE;
                            else if (aborting)        st[i] <= W_RST;
                            else if (st[i] == W_LOAD) st[i] <= W_GO;
                            else                      st[i] <= W_RUN;
                        end
                    end
                    W_RUN: begin
                        if (aborting) begin
                            st[i] <= W_RST;
                        end else if (w_done[i]) begin
                            cnt[i] <= w_counter[64*i +: 64];
                            st[i]  <= W_RESULT;
                        end
                    end
                    W_RESULT: begin
                        if (accept && res_worker == WID_W'(i)) st[i] <= W_RST;
                    end
                    default: st[i] <= W_IDLE;
                endcase
            end
        end
    end

    // Command buses follow each worker's phase; valid drops once read is seen
    always_comb begin
        w_cmd       = '0;
        w_cmd_valid = '0;
        w_region    = '0;
        for (int i = 0; i < NUM_WORKERS; i++) begin
            if (st[i] == W_GO)       w_cmd[32*i +: 32] = CMD_START;
            else if (st[i] == W_RST) w_cmd[32*i +: 32] = CMD_RESTART;
            else                     w_cmd[32*i +: 32] = CMD_READ;
            w_cmd_valid[i]       = ((st[i] == W_LOAD) || (st[i] == W_GO) ||
                                    (st[i] == W_RST)) && !hs[i];
            w_region[32*i +: 32] = rgn[i];
        end
    end

    // Registered result slot; the shown worker stays in W_RESULT until taken
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            res_valid   <= 1'b0;
            res_region  <= '0;
            res_counter <= '0;
            res_worker  <= '0;
            rr_ptr      <= '0;
        end else if (accept) begin
            res_valid <= 1'b0;
            rr_ptr    <= (res_worker == WID_W'(NUM_WORKERS - 1)) ? '0 :
                         res_worker + 1'b1;
        end else if (!res_valid && sel_ok) begin
            res_valid   <= 1'b1;
            res_worker  <= sel_idx;
            res_region  <= rgn[sel_idx];
            res_counter <= cnt[sel_idx];
        end
    end

    // Job bookkeeping: region cursor, abort flag, busy and done pulse
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy        <= 1'b0;
            job_done    <= 1'b0;
            aborting    <= 1'b0;
            next_region <= '0;
            remaining   <= '0;
        end else begin
            job_done <= 1'b0;
            if (!busy) begin
                if (start) begin
                    busy        <= 1'b1;
                    aborting    <= 1'b0;
                    next_region <= region_base;
                    remaining   <= region_count;
                end
            end else begin
                if (abort) aborting <= 1'b1;
                if (alloc) begin
                    next_region <= next_region + 32'd1;
                    remaining   <= remaining - 32'd1;
                end
                if (job_end) begin
                    busy     <= 1'b0;
                    aborting <= 1'b0;
                    job_done <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_des_region_scheduler.sv
// Bench for des_region_scheduler: behavioural DES wrappers, a random-ready
// result consumer and a set-based scoreboard of regions and counters.
module tb_des_region_scheduler;

    localparam int NW = 4;
    localparam int WW = 2;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            start = 1'b0;
    logic            abort = 1'b0;
    logic [31:0]     region_base = '0;
    logic [31:0]     region_count = '0;
    logic            busy;
    logic            job_done;
    logic [32*NW-1:0] w_cmd;
    logic [NW-1:0]   w_cmd_valid;
    logic [32*NW-1:0] w_region;
    logic [NW-1:0]   w_cmd_read = '0;
    logic [NW-1:0]   w_done = '0;
    logic [64*NW-1:0] w_counter = '0;
    logic            res_valid;
    logic            res_ready = 1'b0;
    logic [31:0]     res_region;
    logic [63:0]     res_counter;
    logic [WW-1:0]   res_worker;

    des_region_scheduler #(.NUM_WORKERS(NW), .WID_W(WW)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .region_base(region_base), .region_count(region_count),
        .busy(busy), .job_done(job_done),
        .w_cmd(w_cmd), .w_cmd_valid(w_cmd_valid), .w_region(w_region),
        .w_cmd_read(w_cmd_read), .w_done(w_done), .w_counter(w_counter),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_region(res_region), .res_counter(res_counter),
        .res_worker(res_worker)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    // scoreboard state
    logic [31:0] issued[$];
    logic [31:0] res_r[$];
    int          res_w[$];
    int          owner[logic [31:0]];
    int          jd_cnt = 0;
    int          rs_cnt = 0;
    bit          cv_seen = 0;

    // wrapper model controls
    bit          manual = 0;
    bit          fix100 = 0;
    logic [NW-1:0] rel = '0;
    logic [NW-1:0] run = '0;
    int          rdy_mode = 0;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] ctr_of(input logic [31:0] r, input int w);
        return {~r, r + 32'(w)};
    endfunction

    task automatic clear_sb();
        issued.delete();
        res_r.delete();
        res_w.delete();
        owner.delete();
        jd_cnt  = 0;
        rs_cnt  = 0;
        cv_seen = 0;
    endtask

    always @(negedge clk) begin
        if (!rst && job_done) jd_cnt++;
        if (!rst && |w_cmd_valid) cv_seen = 1;
    end

    // Behavioural DES wrappers
    for (genvar gi = 0; gi < NW; gi++) begin : g_w
        initial begin
            int dly;
            int left;
            int last;
            logic [31:0] rg;
            logic [31:0] c;
            bit ok;
            dly = 0; left = 0; last = 3; rg = '0; c = '0;
            forever begin
                @(posedge clk); #1;
                if (rst) begin
                    w_cmd_read[gi] = 1'b0;
                    w_done[gi] = 1'b0;
                    run[gi] = 1'b0;
                    last = 3; dly = 0;
                    continue;
                end
                if (!w_cmd_read[gi] && w_cmd_valid[gi]) begin
                    if (dly > 0) dly--;
                    else begin
                        w_cmd_read[gi] = 1'b1;
                        dly = $urandom_range(0, 2);
                        c = w_cmd[32*gi +: 32];
                        ok = (c == 0 && last == 3) || (c == 1 && last == 0) ||
                             (c == 3 && last != 3);
                        check("cmd_seq", ok, 1);
                        last = int'(c);
                        if (c == 0) begin
                            rg = w_region[32*gi +: 32];
                            check("reissue", owner.exists(rg), 0);
                            issued.push_back(rg);
                            owner[rg] = gi;
                        end else if (c == 1) begin
                            run[gi] = 1'b1;
                            left = fix100 ? 100 : $urandom_range(3, 40);
                        end else begin
                            run[gi] = 1'b0;
                            w_done[gi] = 1'b0;
                            rs_cnt++;
                        end
                    end
                end else if (w_cmd_read[gi] && !w_cmd_valid[gi]) begin
                    w_cmd_read[gi] = 1'b0;
                end
                if (run[gi] && !w_done[gi]) begin
                    if (manual ? rel[gi] : (left <= 1)) begin
                        w_done[gi] = 1'b1;
                        w_counter[64*gi +: 64] = ctr_of(rg, gi);
                    end else if (!manual) begin
                        left--;
                    end
                end
            end
        end
    end

    // Result consumer with hold-stability checks
    initial begin
        bit hold_v;
        logic [31:0] h_rg;
        logic [63:0] h_ct;
        int h_w;
        hold_v = 0; h_rg = '0; h_ct = '0; h_w = 0;
        forever begin
            @(posedge clk); #1;
            if (rst) begin
                hold_v = 0;
                continue;
            end
            if (hold_v) begin
                check("hold_v", res_valid, 1);
                check("hold_rg", res_region, h_rg);
                check("hold_ct", res_counter, h_ct);
                check("hold_w", res_worker, h_w);
            end
            case (rdy_mode)
                1:       res_ready = 1'b0;
                2:       res_ready = 1'b1;
                default: res_ready = 1'($urandom_range(0, 1));
            endcase
            if (res_valid && res_ready) begin
                res_r.push_back(res_region);
                res_w.push_back(int'(res_worker));
                check("ctr", res_counter, ctr_of(res_region, int'(res_worker)));
                check("owner", owner.exists(res_region) ? owner[res_region] : -1,
                      int'(res_worker));
            end
            hold_v = res_valid && !res_ready;
            h_rg = res_region;
            h_ct = res_counter;
            h_w  = int'(res_worker);
        end
    end

    task automatic start_job(input logic [31:0] b, input logic [31:0] c);
        @(posedge clk); #1;
        clear_sb();
        region_base  = b;
        region_count = c;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        for (int k = 0; k < budget && jd_cnt == 0; k++) begin
            @(posedge clk); #2;
        end
        check({tag, "_tmo"}, jd_cnt > 0, 1);
        repeat (3) @(posedge clk);
        #2;
    endtask

    task automatic verify(input string tag, input logic [31:0] b, input int c,
                          input int nres, input int niss);
        bit seen[64];
        logic [31:0] off;
        foreach (seen[k]) seen[k] = 0;
        check({tag, "_nres"}, res_r.size(), nres);
        check({tag, "_niss"}, issued.size(), niss);
        check({tag, "_jd"}, jd_cnt, 1);
        check({tag, "_busy"}, busy, 0);
        foreach (res_r[k]) begin
            off = res_r[k] - b;
            check({tag, "_rng"}, off < 32'(c), 1);
            if (off < 64) begin
                check({tag, "_dup"}, seen[off[5:0]], 0);
                seen[off[5:0]] = 1;
            end
        end
    endtask

    initial begin
        logic [31:0] b;
        int c;
        logic [31:0] s_rg;
        logic [63:0] s_ct;

        repeat (3) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_jd", job_done, 0);
        check("rst_cv", w_cmd_valid, 0);
        check("rst_rv", res_valid, 0);
        check("rst_cmd", w_cmd, 0);
        @(negedge clk);
        rst = 1'b0;

        // basic job: 4 regions, fixed 100-cycle search
        fix100 = 1;
        start_job(32'h10, 4);
        wait_done("t1", 1500);
        verify("t1", 32'h10, 4, 4, 4);
        for (int i = 0; i < NW; i++)
            check("t1_map", owner.exists(32'h10 + i) ? owner[32'h10 + i] : -1, i);
        fix100 = 0;

        // more regions than workers, random timing
        start_job(32'h10, 9);
        wait_done("t2", 3000);
        verify("t2", 32'h10, 9, 9, 9);

        // random jobs, first one wraps past 0xffffffff
        for (int it = 0; it < 5; it++) begin
            b = (it == 0) ? 32'hFFFF_FFFC : $urandom;
            c = $urandom_range(1, 12);
            start_job(b, c);
            wait_done("rnd", 3000);
            verify("rnd", b, c, c, c);
        end

        // round-robin ordering and hold while stalled
        manual = 1;
        rdy_mode = 2;
        rel = '0;
        start_job(32'h10, 5);
        for (int k = 0; k < 200 && run != 4'hF; k++) begin @(posedge clk); #2; end
        check("t3_run", run, 4'hF);
        rel = 4'b0010;
        for (int k = 0; k < 200 && res_r.size() < 1; k++) begin @(posedge clk); #2; end
        rel = '0;
        check("t3_first", res_r.size() > 0 ? res_w[0] : -1, 1);
        for (int k = 0; k < 200 && !(rs_cnt == 1 && run[1]); k++) begin
            @(posedge clk); #2;
        end
        check("t3_rerun", run[1], 1);
        rdy_mode = 1;
        rel = 4'b1010;
        repeat (8) @(posedge clk);
        #2;
        check("t3_rv", res_valid, 1);
        check("t3_w3", res_worker, 3);
        check("t3_r3", res_region, 32'h13);
        s_rg = res_region;
        s_ct = res_counter;
        repeat (4) @(posedge clk);
        #2;
        check("t3_hold_rg", res_region, s_rg);
        check("t3_hold_ct", res_counter, s_ct);
        rdy_mode = 2;
        for (int k = 0; k < 200 && res_r.size() < 3; k++) begin @(posedge clk); #2; end
        check("t3_ord1", res_r.size() > 2 ? res_w[1] : -1, 3);
        check("t3_ord2", res_r.size() > 2 ? res_w[2] : -1, 1);
        check("t3_rg2", res_r.size() > 2 ? res_r[2] : 0, 32'h14);
        rel = 4'b1111;
        wait_done("t3", 500);
        verify("t3", 32'h10, 5, 5, 5);
        rel = '0;
        manual = 0;
        rdy_mode = 0;

        // empty job
        start_job(32'h30, 0);
        check("t4_busy1", busy, 1);
        @(posedge clk); #2;
        check("t4_busy0", busy, 0);
        check("t4_jd", job_done, 1);
        repeat (4) @(posedge clk);
        #2;
        check("t4_jdcnt", jd_cnt, 1);
        check("t4_nocv", cv_seen, 0);

        // abort with one result pending and three searches running
        manual = 1;
        rdy_mode = 1;
        start_job(32'h40, 8);
        for (int k = 0; k < 200 && run != 4'hF; k++) begin @(posedge clk); #2; end
        check("t5_run", run, 4'hF);
        rel = 4'b0001;
        for (int k = 0; k < 50 && !res_valid; k++) begin @(posedge clk); #2; end
        check("t5_rv", res_valid, 1);
        @(posedge clk); #1;
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        repeat (30) @(posedge clk);
        #2;
        check("t5_rst3", rs_cnt, 3);
        check("t5_busy", busy, 1);
        check("t5_nres0", res_r.size(), 0);
        rdy_mode = 2;
        wait_done("t5", 300);
        verify("t5", 32'h40, 8, 1, 4);
        check("t5_rg", res_r.size() > 0 ? res_r[0] : 0, 32'h40);
        check("t5_rst4", rs_cnt, 4);
        rel = '0;
        manual = 0;
        rdy_mode = 0;

        // asynchronous reset during a READ_REGION handshake
        manual = 1;
        start_job(32'h20, 4);
        for (int k = 0; k < 20 && !w_cmd_valid[0]; k++) begin @(posedge clk); #2; end
        check("t6_cv", w_cmd_valid[0], 1);
        #1;
        rst = 1'b1;
        #1;
        check("t6_cv0", w_cmd_valid, 0);
        check("t6_busy", busy, 0);
        @(negedge clk);
        @(negedge clk);
        clear_sb();
        manual = 0;
        rst = 1'b0;
        start_job(32'h55, 1);
        wait_done("t6", 300);
        verify("t6", 32'h55, 1, 1, 1);
        check("t6_iss", issued.size() > 0 ? issued[0] : 0, 32'h55);
        check("t6_w0", owner.exists(32'h55) ? owner[32'h55] : -1, 0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout got=1 exp=0");
        $fatal(1, "timeout");
    end

endmodule
